// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared types and constants for the OAM DMA bus arbiter
// Holds the DMA sequencer state encoding, the CPU read-return select, the
// DMA register address, the OAM base address and the echo-RAM clamp helper.
package gb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RD,
        WR
    } dma_state_t;

    // Source of cpu_din in the cycle after a CPU read.
    typedef enum logic [1:0] {
        RSEL_FF,
        RSEL_MEM,
        RSEL_REG
    } rsel_t;

    localparam logic [15:0] DMA_REG_ADDR_C = 16'hFF46;
    localparam logic [15:0] OAM_BASE       = 16'hFE00;
    localparam logic [7:0]  ECHO_LO        = 8'hE0;

    // Pages E0..FF alias onto C0..DF, so the DMA reads the real WRAM behind
    // the echo region instead of the OAM/IO space.
    function automatic logic [7:0] echo_clamp(input logic [7:0] page);
        return (page >= ECHO_LO) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma_seq.sv
// rtl/oam_dma_seq.sv - OAM DMA sequencer: trigger edge detect, FSM, byte index, source page
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   reg_wr_i       CPU write strobe qualified with the DMA register address
//   wdata_i        CPU write data (source page)
//   hi_req_i       CPU access to the high page this cycle (stalls a DMA read)
//   state_o        current sequencer state
//   idx_o          byte index within the transfer
//   src_hi_o       source page register
module oam_dma_seq
    import gb_bus_pkg::*;
#(
    parameter int DMA_LEN     = 160,
    parameter int START_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reg_wr_i,
    input  logic [7:0] wdata_i,
    input  logic       hi_req_i,
    output dma_state_t state_o,
    output logic [7:0] idx_o,
    output logic [7:0] src_hi_o
);

    localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);
    localparam logic [7:0] CNT_LAST = 8'(START_DELAY - 1);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] cnt_q, cnt_d;
    logic       reg_wr_prev_q;
    logic       trig;

    // A strobe held over several cycles starts only one transfer.
    assign trig = reg_wr_i & ~reg_wr_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= 8'h00;
            src_hi_q      <= 8'h00;
            cnt_q         <= 8'h00;
            reg_wr_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            src_hi_q      <= src_hi_d;
            cnt_q         <= cnt_d;
            reg_wr_prev_q <= reg_wr_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: ;
            DELAY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RD;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            RD: begin
                if (!hi_req_i) begin
                    state_d = WR;
                end
            end
            WR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new trigger overrides whatever the FSM chose, including a restart
        // mid-copy; the current WR output still goes out this cycle.
        if (trig) begin
            src_hi_d = echo_clamp(wdata_i);
            idx_d    = 8'h00;
            cnt_d    = 8'h00;
            state_d  = DELAY;
        end
    end

    assign state_o  = state_q;
    assign idx_o    = idx_q;
    assign src_hi_o = src_hi_q;

endmodule

// File: rtl/oam_dma_bus_arbiter.sv
// rtl/oam_dma_bus_arbiter.sv - shares the CPU memory bus between the CPU and the OAM DMA engine
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   cpu_addr/cpu_dout                  CPU address and write data
//   cpu_mreq_n/cpu_rd_n/cpu_wr_n       CPU strobes, active low
//   cpu_din                            read data returned to the CPU (one cycle after the read)
//   mem_addr/mem_wdata/mem_rd/mem_wr   memory bus towards the decoder
//   mem_rdata                          memory read data, one cycle after mem_rd
//   oam_addr/oam_wdata/oam_we          OAM RAM write port
//   dma_active                         DMA owns the bus
//   dma_src_hi                         current DMA source page
module oam_dma_bus_arbiter
    import gb_bus_pkg::*;
#(
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_C,
    parameter logic [7:0]  HIGH_PAGE    = 8'hFF,
    parameter int          START_DELAY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic [7:0]  cpu_din,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active,
    output logic [7:0]  dma_src_hi
);

    logic       cpu_rd, cpu_wr, hi, reg_hit, hi_req;
    logic       granted, dma_rd;
    dma_state_t state;
    logic [7:0] idx;
    logic [7:0] src_hi;
    rsel_t      rsel_q, rsel_d;

    assign cpu_rd  = ~cpu_mreq_n & ~cpu_rd_n;
    assign cpu_wr  = ~cpu_mreq_n & ~cpu_wr_n;
    assign hi      = (cpu_addr[15:8] == HIGH_PAGE);
    assign reg_hit = (cpu_addr == DMA_REG_ADDR);
    assign hi_req  = (cpu_rd | cpu_wr) & hi;

    oam_dma_seq #(
        .DMA_LEN     (DMA_LEN),
        .START_DELAY (START_DELAY)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .reg_wr_i (cpu_wr & reg_hit),
        .wdata_i  (cpu_dout),
        .hi_req_i (hi_req),
        .state_o  (state),
        .idx_o    (idx),
        .src_hi_o (src_hi)
    );

    assign dma_active = (state != IDLE);
    assign dma_src_hi = src_hi;
    assign granted    = ~dma_active | hi;
    // A high-page CPU access in RD takes the port and the DMA read waits.
    assign dma_rd     = (state == RD) & ~hi_req;

    // Outputs are forced to their rest values while reset is held so the
    // combinational pass-through cannot leak CPU activity onto the bus.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        oam_addr  = 8'h00;
        oam_wdata = 8'h00;
        oam_we    = 1'b0;
        if (!reset) begin
            if (dma_rd) begin
                mem_addr = {src_hi, idx};
                mem_rd   = 1'b1;
            end else if (granted) begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_dout;
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr & ~reg_hit;
            end
            if (state == WR) begin
                oam_we    = 1'b1;
                oam_addr  = idx;
                oam_wdata = mem_rdata;
            end
        end
    end

    always_comb begin
        rsel_d = RSEL_FF;
        if (cpu_rd) begin
            if (reg_hit) begin
                rsel_d = RSEL_REG;
            end else if (granted) begin
                rsel_d = RSEL_MEM;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsel_q <= RSEL_FF;
        end else begin
            rsel_q <= rsel_d;
        end
    end

    always_comb begin
        case (rsel_q)
            RSEL_MEM: cpu_din = mem_rdata;
            RSEL_REG: cpu_din = src_hi;
            default:  cpu_din = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// tb/tb_oam_dma_bus_arbiter.sv - scoreboard bench for the OAM DMA bus arbiter
module tb_oam_dma_bus_arbiter;

    localparam int K_GRANT_RD = 0;
    localparam int K_BLOCK    = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
    logic [7:0]  cpu_din;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  oam_addr, oam_wdata;
    logic        oam_we, dma_active;
    logic [7:0]  dma_src_hi;

    int checks = 0;
    int errors = 0;

    logic [15:0] oam_q[$];
    logic [7:0]  rd_q[$];
    bus_exp_t    bus_q[$];
    int          dur_q[$];

    always #5 clk = ~clk;

    oam_dma_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_din    (cpu_din),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata),
        .oam_we     (oam_we),
        .dma_active (dma_active),
        .dma_src_hi (dma_src_hi)
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [7:0] t;
        t = a[15:8] + 8'h5A;
        return a[7:0] ^ t;
    endfunction

    // Synchronous RAM model: one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_byte(mem_addr);
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    logic rd_prev = 1'b0;
    int   act_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || oam_we !== 1'b0 || dma_active !== 1'b0 ||
                mem_addr !== 16'h0 || mem_wdata !== 8'h0 || oam_addr !== 8'h0 ||
                oam_wdata !== 8'h0 || cpu_din !== 8'hFF) begin
                errors++;
                $display("FAIL reset_outputs rd=%b wr=%b we=%b act=%b maddr=%h mwd=%h oaddr=%h owd=%h din=%h required zeros and din=ff",
                         mem_rd, mem_wr, oam_we, dma_active, mem_addr, mem_wdata, oam_addr, oam_wdata, cpu_din);
            end
            rd_prev = 1'b0;
        end else begin
            if (rd_prev) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_din no expectation queued, got %h", cpu_din);
                end else begin
                    logic [7:0] e;
                    e = rd_q.pop_front();
                    if (cpu_din !== e) begin
                        errors++;
                        $display("FAIL cpu_din got %h required %h", cpu_din, e);
                    end
                end
            end
            rd_prev = !cpu_mreq_n && !cpu_rd_n;
            if (!cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n)) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus no expectation queued for addr %h", cpu_addr);
                end else begin
                    bus_exp_t b;
                    b = bus_q.pop_front();
                    if (b.kind == K_GRANT_RD) begin
                        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== b.addr) begin
                            errors++;
                            $display("FAIL bus_grant got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=%h",
                                     mem_rd, mem_wr, mem_addr, b.addr);
                        end
                    end else begin
                        if (mem_wr !== 1'b0 || (mem_rd === 1'b1 && mem_addr === b.addr)) begin
                            errors++;
                            $display("FAIL bus_block got rd=%b wr=%b addr=%h required wr=0 and no cpu read of %h",
                                     mem_rd, mem_wr, mem_addr, b.addr);
                        end
                    end
                end
            end
            if (oam_we === 1'b1) begin
                checks++;
                if (oam_q.size() == 0) begin
                    errors++;
                    $display("FAIL oam_write unexpected addr=%h data=%h", oam_addr, oam_wdata);
                end else begin
                    logic [15:0] e;
                    e = oam_q.pop_front();
                    if ({oam_addr, oam_wdata} !== e) begin
                        errors++;
                        $display("FAIL oam_write got addr=%h data=%h required addr=%h data=%h",
                                 oam_addr, oam_wdata, e[15:8], e[7:0]);
                    end
                end
            end
        end
        if (dma_active === 1'b1) begin
            act_cnt++;
        end else if (act_cnt > 0) begin
            checks++;
            if (dur_q.size() == 0) begin
                errors++;
                $display("FAIL dma_duration unexpected transfer of %0d cycles", act_cnt);
            end else begin
                int e;
                e = dur_q.pop_front();
                if (act_cnt != e) begin
                    errors++;
                    $display("FAIL dma_duration got %0d required %0d", act_cnt, e);
                end
            end
            act_cnt = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a, input int kind, input logic [7:0] exp_din);
        bus_exp_t b;
        b.kind = kind;
        b.addr = a;
        bus_q.push_back(b);
        rd_q.push_back(exp_din);
        cpu_addr   = a;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        cyc();
        idle_bus();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int kind);
        bus_exp_t b;
        b.kind = kind;
        b.addr = a;
        bus_q.push_back(b);
        cpu_addr   = a;
        cpu_dout   = d;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cyc();
        idle_bus();
    endtask

    // Queues the full expected OAM image from page src, then writes the register.
    task automatic trigger(input logic [7:0] val, input logic [7:0] src, input int dur);
        oam_q.delete();
        for (int i = 0; i < 160; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            oam_q.push_back({ib, mem_byte({src, ib})});
        end
        if (dur >= 0) dur_q.push_back(dur);
        cpu_write(16'hFF46, val, K_BLOCK);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((dma_active || oam_q.size() != 0) && n < 2000) begin
            cyc();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout remaining=%0d required 0", oam_q.size());
        end
        cyc();
        cyc();
    endtask

    task automatic wait_remaining(input int left);
        int n;
        n = 0;
        while (oam_q.size() > left && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_remaining timeout remaining=%0d required %0d", oam_q.size(), left);
        end
    endtask

    initial begin
        reset    = 1'b1;
        cpu_addr = 16'h1234;
        cpu_dout = 8'h55;
        idle_bus();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc();

        // Idle pass-through read.
        cpu_read(16'hC000, K_GRANT_RD, mem_byte(16'hC000));
        cyc();

        // Copy from C100; blocked read/write and register read during the copy.
        trigger(8'hC1, 8'hC1, 321);
        cyc();
        cpu_read(16'h8000, K_BLOCK, 8'hFF);
        cpu_write(16'hC000, 8'h77, K_BLOCK);
        cyc();
        cpu_read(16'hFF46, K_GRANT_RD, 8'hC1);
        wait_done();

        // High-page read in the first RD stalls the copy by one cycle.
        trigger(8'hC3, 8'hC3, 322);
        cyc();
        cpu_read(16'hFF80, K_GRANT_RD, mem_byte(16'hFF80));
        wait_done();

        // Restart at byte 50 from D000; runs 101 cycles + 1 RD + 321.
        trigger(8'hC2, 8'hC2, 423);
        wait_remaining(110);
        trigger(8'hD0, 8'hD0, -1);
        wait_done();

        // Echo clamp E5 -> C5, then reset after ten bytes.
        trigger(8'hE5, 8'hC5, 21);
        cyc();
        cyc();
        cpu_read(16'hFF46, K_GRANT_RD, 8'hC5);
        wait_remaining(150);
        reset = 1'b1;
        oam_q.delete();
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        cyc();
        cpu_read(16'hFF46, K_GRANT_RD, 8'h00);
        repeat (4) cyc();

        checks++;
        if (oam_q.size() != 0 || rd_q.size() != 0 || bus_q.size() != 0 || dur_q.size() != 0) begin
            errors++;
            $display("FAIL leftover oam=%0d rd=%0d bus=%0d dur=%0d required all 0",
                     oam_q.size(), rd_q.size(), bus_q.size(), dur_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
